// File: rtl/tea_arbiter.sv
// Round-robin arbiter that shares one TEA encryption core among NUM_CH requesters.
// One transaction is in flight at a time; a stalled core is abandoned after TIMEOUT cycles.
module tea_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_CH-1:0]         i_req_valid,
  output logic [NUM_CH-1:0]         o_req_ready,
  input  logic [NUM_CH*64-1:0]      i_req_data,
  input  logic [NUM_CH*128-1:0]     i_key,
  output logic [NUM_CH-1:0]         o_rsp_valid,
  input  logic [NUM_CH-1:0]         i_rsp_ready,
  output logic [63:0]               o_rsp_data,
  output logic                      o_core_valid,
  input  logic                      i_core_ready,
  output logic [63:0]               o_core_data,
  output logic [127:0]              o_core_key,
  input  logic                      i_core_valid,
  output logic                      o_core_ready,
  input  logic [63:0]               i_core_data,
  output logic [$clog2(NUM_CH)-1:0] o_grant_id,
  output logic                      o_busy,
  output logic                      o_timeout
);

  localparam int GW = $clog2(NUM_CH);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RETURN
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   sel;
  logic            any_req;
  logic [63:0]     data_q;
  logic [127:0]    key_q;
  logic [63:0]     rsp_q;
  logic [CW-1:0]   count;
  logic            accept;
  logic            result_hit;
  logic            timeout_hit;
  logic            rsp_done;

  // Descending scan so the candidate nearest after last_grant is written last and wins.
  always_comb begin
    int            idx;
    logic [GW-1:0] cand;
    sel     = last_grant;
    any_req = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = GW'(idx);
      if (i_req_valid[cand]) begin
        sel     = cand;
        any_req = 1'b1;
      end
    end
  end

  // The counter is compared one step early so the pulse lands in the cycle it reaches TIMEOUT-1.
  always_comb begin
    accept      = (state == IDLE) && any_req;
    result_hit  = (state == WAIT) && i_core_valid;
    timeout_hit = ((state == ISSUE) || (state == WAIT)) &&
                  (count == CW'(TIMEOUT - 2)) && !result_hit;
    rsp_done    = (state == RETURN) && i_rsp_ready[grant];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (timeout_hit)       state_nxt = IDLE;
        else if (i_core_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (result_hit)       state_nxt = RETURN;
        else if (timeout_hit) state_nxt = IDLE;
      end
      RETURN: begin
        if (rsp_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant <= GW'(NUM_CH - 1);
      grant      <= '0;
      data_q     <= '0;
      key_q      <= '0;
      rsp_q      <= '0;
      count      <= '0;
    end else begin
      if (accept) begin
        grant  <= sel;
        data_q <= i_req_data[64*sel +: 64];
        key_q  <= i_key[128*sel +: 128];
        count  <= '0;
      end else if ((state == ISSUE) || (state == WAIT)) begin
        count <= count + CW'(1);
      end
      if (result_hit) rsp_q <= i_core_data;
      if (rsp_done || timeout_hit) last_grant <= grant;
    end
  end

  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    if (accept)           o_req_ready[sel]   = 1'b1;
    if (state == RETURN)  o_rsp_valid[grant] = 1'b1;
  end

  // In ISSUE the valid is withdrawn during the timeout cycle so the core never takes an orphaned job.
  assign o_core_valid = (state == ISSUE) && !timeout_hit;
  assign o_core_ready = (state == WAIT);
  assign o_core_data  = data_q;
  assign o_core_key   = key_q;
  assign o_rsp_data   = rsp_q;
  assign o_timeout    = timeout_hit;
  assign o_busy       = (state != IDLE);
  assign o_grant_id   = (state == IDLE) ? last_grant : grant;

endmodule

// File: tb/tb_tea_arbiter.sv
// Directed bench for tea_arbiter: a cycle table for a basic two-transaction flow,
// then hand-written sequences for round-robin, backpressure, timeout and reset corners.
module tb_tea_arbiter;

  localparam int NUM_CH  = 4;
  localparam int TIMEOUT = 64;

  logic                  i_clk;
  logic                  i_rst;
  logic [NUM_CH-1:0]     i_req_valid;
  logic [NUM_CH-1:0]     o_req_ready;
  logic [NUM_CH*64-1:0]  i_req_data;
  logic [NUM_CH*128-1:0] i_key;
  logic [NUM_CH-1:0]     o_rsp_valid;
  logic [NUM_CH-1:0]     i_rsp_ready;
  logic [63:0]           o_rsp_data;
  logic                  o_core_valid;
  logic                  i_core_ready;
  logic [63:0]           o_core_data;
  logic [127:0]          o_core_key;
  logic                  i_core_valid;
  logic                  o_core_ready;
  logic [63:0]           i_core_data;
  logic [1:0]            o_grant_id;
  logic                  o_busy;
  logic                  o_timeout;

  tea_arbiter #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_data  (i_req_data),
    .i_key       (i_key),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_core_valid(o_core_valid),
    .i_core_ready(i_core_ready),
    .o_core_data (o_core_data),
    .o_core_key  (o_core_key),
    .i_core_valid(i_core_valid),
    .o_core_ready(o_core_ready),
    .i_core_data (i_core_data),
    .o_grant_id  (o_grant_id),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  logic [63:0]  data_tab [NUM_CH];
  logic [127:0] key_tab  [NUM_CH];

  typedef struct {
    logic [3:0]  req_valid;
    logic        core_ready;
    logic        core_valid;
    logic [63:0] core_data;
    logic [3:0]  rsp_ready;
    logic [3:0]  exp_req_ready;
    logic        exp_core_valid;
    logic        exp_core_ready;
    logic [3:0]  exp_rsp_valid;
    logic [63:0] exp_rsp_data;
    logic        exp_busy;
    logic [1:0]  exp_grant;
    logic        exp_timeout;
  } vec_t;

  vec_t vecs [14];

  localparam logic [63:0] X1 = 64'h1111_AAAA_2222_BBBB;
  localparam logic [63:0] X2 = 64'h3333_CCCC_4444_DDDD;

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_req_valid  = v.req_valid;
    i_core_ready = v.core_ready;
    i_core_valid = v.core_valid;
    i_core_data  = v.core_data;
    i_rsp_ready  = v.rsp_ready;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkVal($sformatf("v%0d_req_ready", idx), 128'(o_req_ready), 128'(v.exp_req_ready));
    checkVal($sformatf("v%0d_core_valid", idx), 128'(o_core_valid), 128'(v.exp_core_valid));
    checkVal($sformatf("v%0d_core_ready", idx), 128'(o_core_ready), 128'(v.exp_core_ready));
    checkVal($sformatf("v%0d_rsp_valid", idx), 128'(o_rsp_valid), 128'(v.exp_rsp_valid));
    checkVal($sformatf("v%0d_busy", idx), 128'(o_busy), 128'(v.exp_busy));
    checkVal($sformatf("v%0d_grant_id", idx), 128'(o_grant_id), 128'(v.exp_grant));
    checkVal($sformatf("v%0d_timeout", idx), 128'(o_timeout), 128'(v.exp_timeout));
    if (v.exp_rsp_valid != 4'b0000)
      checkVal($sformatf("v%0d_rsp_data", idx), 128'(o_rsp_data), 128'(v.exp_rsp_data));
    if (v.exp_core_valid || v.exp_core_ready) begin
      checkVal($sformatf("v%0d_core_data", idx), 128'(o_core_data), 128'(data_tab[v.exp_grant]));
      checkVal($sformatf("v%0d_core_key", idx), o_core_key, key_tab[v.exp_grant]);
    end
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rst        = 1'b1;
    i_req_valid  = '0;
    i_core_ready = 1'b0;
    i_core_valid = 1'b0;
    i_core_data  = '0;
    i_rsp_ready  = '0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, "_req_ready"}, 128'(o_req_ready), 128'(0));
    checkVal({tag, "_core_valid"}, 128'(o_core_valid), 128'(0));
    checkVal({tag, "_core_ready"}, 128'(o_core_ready), 128'(0));
    checkVal({tag, "_rsp_valid"}, 128'(o_rsp_valid), 128'(0));
    checkVal({tag, "_timeout"}, 128'(o_timeout), 128'(0));
    checkVal({tag, "_busy"}, 128'(o_busy), 128'(0));
    checkVal({tag, "_rsp_data"}, 128'(o_rsp_data), 128'(0));
    checkVal({tag, "_core_data"}, 128'(o_core_data), 128'(0));
    checkVal({tag, "_core_key"}, o_core_key, 128'(0));
    checkVal({tag, "_grant_id"}, 128'(o_grant_id), 128'(3));
  endtask

  // Full handshake for one channel; entered just after a negedge with requests already driven.
  task automatic doTxn(input int exp_ch, input int core_delay, input logic [63:0] result);
    int n;
    n = 0;
    while (o_req_ready == '0 && n < 20) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    checkVal($sformatf("txn%0d_req_ready", exp_ch), 128'(o_req_ready), 128'(1) << exp_ch);
    @(negedge i_clk);
    #1;
    checkVal($sformatf("txn%0d_core_valid", exp_ch), 128'(o_core_valid), 128'(1));
    checkVal($sformatf("txn%0d_grant_id", exp_ch), 128'(o_grant_id), 128'(exp_ch));
    checkVal($sformatf("txn%0d_core_data", exp_ch), 128'(o_core_data), 128'(data_tab[exp_ch]));
    checkVal($sformatf("txn%0d_core_key", exp_ch), o_core_key, key_tab[exp_ch]);
    i_core_ready = 1'b1;
    @(negedge i_clk);
    i_core_ready = 1'b0;
    #1;
    checkVal($sformatf("txn%0d_core_ready", exp_ch), 128'(o_core_ready), 128'(1));
    repeat (core_delay) @(negedge i_clk);
    i_core_valid = 1'b1;
    i_core_data  = result;
    @(negedge i_clk);
    i_core_valid = 1'b0;
    #1;
    checkVal($sformatf("txn%0d_rsp_valid", exp_ch), 128'(o_rsp_valid), 128'(1) << exp_ch);
    checkVal($sformatf("txn%0d_rsp_data", exp_ch), 128'(o_rsp_data), 128'(result));
    i_rsp_ready = 4'(1 << exp_ch);
    @(negedge i_clk);
    i_rsp_ready = '0;
    #1;
    checkVal($sformatf("txn%0d_busy_after", exp_ch), 128'(o_busy), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    int pulse_at;

    data_tab[0] = 64'h1111_2222_3333_4444;
    data_tab[1] = 64'h0123_4567_89AB_CDEF;
    data_tab[2] = 64'hA5A5_5A5A_0F0F_F0F0;
    data_tab[3] = 64'hFEDC_BA98_7654_3210;
    for (int c = 0; c < NUM_CH; c++) begin
      key_tab[c] = {32'(c + 1) * 32'h0101_0101, 32'hDEAD_0000 + 32'(c),
                    32'hBEEF_0000 + 32'(c), 32'h0F0F_0000 + 32'(c)};
      i_req_data[64*c +: 64] = data_tab[c];
      i_key[128*c +: 128]    = key_tab[c];
    end

    vecs[0]  = '{4'b0000, 1'b0, 1'b0, 64'h0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 64'h0, 1'b0, 2'd3, 1'b0};
    vecs[1]  = '{4'b0110, 1'b0, 1'b0, 64'h0, 4'b0000, 4'b0010, 1'b0, 1'b0, 4'b0000, 64'h0, 1'b0, 2'd3, 1'b0};
    vecs[2]  = '{4'b0100, 1'b0, 1'b0, 64'h0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 64'h0, 1'b1, 2'd1, 1'b0};
    vecs[3]  = '{4'b0100, 1'b1, 1'b0, 64'h0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 64'h0, 1'b1, 2'd1, 1'b0};
    vecs[4]  = '{4'b0100, 1'b0, 1'b0, 64'h0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 2'd1, 1'b0};
    vecs[5]  = '{4'b0100, 1'b0, 1'b1, X1,    4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 2'd1, 1'b0};
    vecs[6]  = '{4'b0100, 1'b0, 1'b0, 64'h0, 4'b1101, 4'b0000, 1'b0, 1'b0, 4'b0010, X1,    1'b1, 2'd1, 1'b0};
    vecs[7]  = '{4'b0100, 1'b0, 1'b0, 64'h0, 4'b0010, 4'b0000, 1'b0, 1'b0, 4'b0010, X1,    1'b1, 2'd1, 1'b0};
    vecs[8]  = '{4'b0100, 1'b0, 1'b0, 64'h0, 4'b0000, 4'b0100, 1'b0, 1'b0, 4'b0000, 64'h0, 1'b0, 2'd1, 1'b0};
    vecs[9]  = '{4'b0000, 1'b1, 1'b0, 64'h0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 64'h0, 1'b1, 2'd2, 1'b0};
    vecs[10] = '{4'b0000, 1'b0, 1'b1, X2,    4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 64'h0, 1'b1, 2'd2, 1'b0};
    vecs[11] = '{4'b0000, 1'b0, 1'b0, 64'h0, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0100, X2,    1'b1, 2'd2, 1'b0};
    vecs[12] = '{4'b1001, 1'b0, 1'b0, 64'h0, 4'b0000, 4'b1000, 1'b0, 1'b0, 4'b0000, 64'h0, 1'b0, 2'd2, 1'b0};
    vecs[13] = '{4'b0000, 1'b0, 1'b0, 64'h0, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 64'h0, 1'b1, 2'd3, 1'b0};

    i_rst        = 1'b1;
    i_req_valid  = '0;
    i_core_ready = 1'b0;
    i_core_valid = 1'b0;
    i_core_data  = '0;
    i_rsp_ready  = '0;

    $display("[TB] reset values");
    doReset();
    #1;
    checkResetOutputs("por");

    $display("[TB] cycle table");
    for (int i = 0; i < 14; i++) begin
      @(negedge i_clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
    end

    $display("[TB] single request on channel 1");
    doReset();
    i_req_valid = 4'b0010;
    #1;
    doTxn(1, 34, 64'hDEAD_BEEF_CAFE_F00D);

    $display("[TB] round robin with all channels requesting");
    doReset();
    i_req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 5; t++) doTxn(t % 4, 1 + t, 64'hC0FF_EE00_0000_0000 + 64'(t));

    $display("[TB] backpressure on core and response");
    doReset();
    i_req_valid = 4'b0101;
    #1;
    checkVal("bp_accept", 128'(o_req_ready), 128'(4'b0001));
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      i_core_ready = 1'b0;
      #1;
      checkVal($sformatf("bp_issue%0d_core_valid", k), 128'(o_core_valid), 128'(1));
      checkVal($sformatf("bp_issue%0d_core_data", k), 128'(o_core_data), 128'(data_tab[0]));
      checkVal($sformatf("bp_issue%0d_core_key", k), o_core_key, key_tab[0]);
      checkVal($sformatf("bp_issue%0d_req_ready", k), 128'(o_req_ready), 128'(0));
    end
    @(negedge i_clk);
    i_core_ready = 1'b1;
    #1;
    checkVal("bp_issue_go", 128'(o_core_valid), 128'(1));
    @(negedge i_clk);
    i_core_ready = 1'b0;
    #1;
    checkVal("bp_wait_core_ready", 128'(o_core_ready), 128'(1));
    checkVal("bp_wait_core_data", 128'(o_core_data), 128'(data_tab[0]));
    checkVal("bp_wait_core_key", o_core_key, key_tab[0]);
    @(negedge i_clk);
    i_core_valid = 1'b1;
    i_core_data  = 64'h5555_6666_7777_8888;
    @(negedge i_clk);
    i_core_valid = 1'b0;
    i_core_data  = 64'h0;
    i_rsp_ready  = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge i_clk);
      #1;
      checkVal($sformatf("bp_ret%0d_rsp_valid", k), 128'(o_rsp_valid), 128'(4'b0001));
      checkVal($sformatf("bp_ret%0d_rsp_data", k), 128'(o_rsp_data), 128'(64'h5555_6666_7777_8888));
      checkVal($sformatf("bp_ret%0d_req_ready", k), 128'(o_req_ready), 128'(0));
    end
    @(negedge i_clk);
    i_rsp_ready = 4'b0001;
    #1;
    checkVal("bp_ret_final", 128'(o_rsp_valid), 128'(4'b0001));
    @(negedge i_clk);
    i_rsp_ready = '0;
    #1;
    checkVal("bp_next_grant", 128'(o_req_ready), 128'(4'b0100));
    checkVal("bp_idle_busy", 128'(o_busy), 128'(0));
    checkVal("bp_idle_grant_id", 128'(o_grant_id), 128'(0));

    $display("[TB] core never answers");
    doReset();
    i_req_valid = 4'b0110;
    #1;
    checkVal("to_accept", 128'(o_req_ready), 128'(4'b0010));
    pulses   = 0;
    pulse_at = -1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge i_clk);
      i_core_ready = (k == 1);
      #1;
      if (o_timeout) begin
        pulses++;
        pulse_at = k;
      end
    end
    checkVal("to_pulse_count", 128'(pulses), 128'(1));
    checkVal("to_pulse_cycle", 128'(pulse_at), 128'(TIMEOUT - 1));
    checkVal("to_busy_after", 128'(o_busy), 128'(0));
    checkVal("to_core_ready_after", 128'(o_core_ready), 128'(0));
    checkVal("to_no_rsp", 128'(o_rsp_valid), 128'(0));
    checkVal("to_last_grant", 128'(o_grant_id), 128'(1));
    checkVal("to_next_grant", 128'(o_req_ready), 128'(4'b0100));

    $display("[TB] result races the timeout");
    doReset();
    i_req_valid = 4'b0001;
    #1;
    checkVal("race_accept", 128'(o_req_ready), 128'(4'b0001));
    pulses = 0;
    for (int k = 1; k <= 62; k++) begin
      @(negedge i_clk);
      i_core_ready = (k == 1);
      i_req_valid  = '0;
      #1;
      if (o_timeout) pulses++;
    end
    @(negedge i_clk);
    i_core_valid = 1'b1;
    i_core_data  = 64'h0BAD_F00D_1234_5678;
    #1;
    if (o_timeout) pulses++;
    checkVal("race_no_timeout", 128'(pulses), 128'(0));
    @(negedge i_clk);
    i_core_valid = 1'b0;
    #1;
    checkVal("race_rsp_valid", 128'(o_rsp_valid), 128'(4'b0001));
    checkVal("race_rsp_data", 128'(o_rsp_data), 128'(64'h0BAD_F00D_1234_5678));
    i_rsp_ready = 4'b0001;
    @(negedge i_clk);
    i_rsp_ready = '0;
    #1;
    checkVal("race_idle", 128'(o_busy), 128'(0));

    $display("[TB] reset during WAIT");
    doReset();
    i_req_valid = 4'b0001;
    #1;
    checkVal("rw_accept", 128'(o_req_ready), 128'(4'b0001));
    @(negedge i_clk);
    i_req_valid  = '0;
    i_core_ready = 1'b1;
    @(negedge i_clk);
    i_core_ready = 1'b0;
    #1;
    checkVal("rw_in_wait", 128'(o_core_ready), 128'(1));
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    checkResetOutputs("rw");
    i_req_valid = 4'b0100;
    #1;
    doTxn(2, 3, 64'h2222_3333_4444_5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
